// File: rtl/dmem_copy_engine_pkg.sv
// Shared constants and types for the data-memory copy/fill engine.
// Widths, mode encodings, FSM states and the length clamp.
package dmem_copy_engine_pkg;

   localparam int ADDR_W    = 6;
   localparam int DATA_W    = 32;
   localparam int LEN_W     = ADDR_W + 1;
   localparam int MEM_DEPTH = 64;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

   function automatic logic [LEN_W-1:0] clamp_len(
      input logic [LEN_W-1:0] len
   );
      if (len > LEN_W'(MEM_DEPTH))
         return LEN_W'(MEM_DEPTH);
      return len;
   endfunction

endpackage

// File: rtl/dmem_copy_ctr.sv
// Source/destination pointers plus remaining and completed word counters.
// Load seeds a transfer; each step advances one written word.
module dmem_copy_ctr
   import dmem_copy_engine_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [LEN_W-1:0]  len_in,
   output logic [ADDR_W-1:0] src_ptr,
   output logic [ADDR_W-1:0] dst_ptr,
   output logic [LEN_W-1:0]  remain,
   output logic [LEN_W-1:0]  words_done,
   output logic              last
);

   // Pointers wrap naturally at the memory depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ptr    <= '0;
         dst_ptr    <= '0;
         remain     <= '0;
         words_done <= '0;
      end else if (load) begin
         src_ptr    <= src_base;
         dst_ptr    <= dst_base;
         remain     <= len_in;
         words_done <= '0;
      end else if (step) begin
         src_ptr    <= src_ptr + 1'b1;
         dst_ptr    <= dst_ptr + 1'b1;
         remain     <= remain - 1'b1;
         words_done <= words_done + 1'b1;
      end
   end

   assign last = (remain == LEN_W'(1));

endmodule

// File: rtl/dmem_copy_engine.sv
// Block copy / block fill master for the 64x32 data memory port.
// Copy alternates read and write cycles; fill writes every cycle.
module dmem_copy_engine
   import dmem_copy_engine_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic              Mode,
   input  logic              Abort,
   input  logic [ADDR_W-1:0] SrcAddr,
   input  logic [ADDR_W-1:0] DstAddr,
   input  logic [LEN_W-1:0]  Length,
   input  logic [DATA_W-1:0] FillValue,
   output logic              Busy,
   output logic              Done,
   output logic              Aborted,
   output logic [LEN_W-1:0]  WordsDone,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W-1:0] ReadData
);

   state_t              state;
   logic                mode_q;
   logic [DATA_W-1:0]   fill_q;
   logic [DATA_W-1:0]   data_q;
   logic [LEN_W-1:0]    len_c;
   logic [ADDR_W-1:0]   src_ptr;
   logic [ADDR_W-1:0]   dst_ptr;
   logic [LEN_W-1:0]    remain;
   logic                last;
   logic                load;
   logic                step;

   assign len_c = clamp_len(Length);
   assign load  = (state == IDLE) && Start;
   assign step  = (state == WR);

   dmem_copy_ctr u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .step       (step),
      .src_base   (SrcAddr),
      .dst_base   (DstAddr),
      .len_in     (len_c),
      .src_ptr    (src_ptr),
      .dst_ptr    (dst_ptr),
      .remain     (remain),
      .words_done (WordsDone),
      .last       (last)
   );

   // Transfer sequencing with registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mode_q  <= MODE_COPY;
         fill_q  <= '0;
         data_q  <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Aborted <= 1'b0;
      end else begin
         Done    <= 1'b0;
         Aborted <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Start) begin
                  mode_q <= Mode;
                  fill_q <= FillValue;
                  Busy   <= 1'b1;
                  if (len_c == '0) begin
                     state <= FIN;
                     Done  <= 1'b1;
                  end else if (Mode == MODE_FILL) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               data_q <= ReadData;
               if (Abort) begin
                  state   <= IDLE;
                  Busy    <= 1'b0;
                  Aborted <= 1'b1;
               end else begin
                  state <= WR;
               end
            end
            WR: begin
               if (Abort) begin
                  state   <= IDLE;
                  Busy    <= 1'b0;
                  Aborted <= 1'b1;
               end else if (last) begin
                  state <= FIN;
                  Done  <= 1'b1;
               end else if (mode_q == MODE_FILL) begin
                  state <= WR;
               end else begin
                  state <= RD;
               end
            end
            FIN: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory strobes decode from state so reset drops them at once.
   always_comb begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      unique case (state)
         RD: begin
            MemRead = 1'b1;
            Address = src_ptr;
         end
         WR: begin
            MemWrite  = 1'b1;
            Address   = dst_ptr;
            WriteData = (mode_q == MODE_FILL) ? fill_q : data_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for the copy/fill engine.
// Memory model, write scoreboard, vector table plus corner sequences.
module tb_dmem_copy_engine;
   import dmem_copy_engine_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              Start;
   logic              Mode;
   logic              Abort;
   logic [ADDR_W-1:0] SrcAddr;
   logic [ADDR_W-1:0] DstAddr;
   logic [LEN_W-1:0]  Length;
   logic [DATA_W-1:0] FillValue;
   logic              Busy;
   logic              Done;
   logic              Aborted;
   logic [LEN_W-1:0]  WordsDone;
   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] WriteData;
   wire  [DATA_W-1:0] ReadData;

   logic [31:0] mem    [64];
   logic [31:0] shadow [64];
   logic        mem_init;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      logic        mode;
      logic [5:0]  src;
      logic [5:0]  dst;
      logic [6:0]  len;
      logic [31:0] fill;
      logic        restart;
      int          exp_cyc;
      int          exp_words;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;

   always #5 clk = ~clk;

   dmem_copy_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Start     (Start),
      .Mode      (Mode),
      .Abort     (Abort),
      .SrcAddr   (SrcAddr),
      .DstAddr   (DstAddr),
      .Length    (Length),
      .FillValue (FillValue),
      .Busy      (Busy),
      .Done      (Done),
      .Aborted   (Aborted),
      .WordsDone (WordsDone),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ReadData  (ReadData)
   );

   function automatic logic [31:0] init_val(input int i);
      case (i)
         2: return 32'd11;
         3: return 32'd22;
         4: return 32'd33;
         5: return 32'd44;
         default: return 32'hA5A5_0000 + 32'(i * 7);
      endcase
   endfunction

   assign ReadData = MemRead ? mem[Address] : 32'hzzzz_zzzz;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++)
            mem[i] <= init_val(i);
      end else if (MemWrite) begin
         mem[Address] <= WriteData;
      end
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && !mem_init) begin
         chk("rd_wr_excl", 32'(MemRead & MemWrite), 0);
         if (MemRead) rd_cnt++;
         if (MemWrite) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected: addr %0d",
                        Address);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(Address), 32'(e.a));
               chk("wr_data", WriteData, e.d);
            end
         end
      end
   end

   task automatic plan(input logic m,
                       input logic [5:0] s,
                       input logic [5:0] d,
                       input logic [6:0] l,
                       input logic [31:0] f,
                       input int nmax);
      int n;
      n = (l > 7'd64) ? 64 : int'(l);
      if (n > nmax) n = nmax;
      for (int i = 0; i < n; i++) begin
         logic [5:0]  a;
         logic [31:0] v;
         a = d + 6'(i);
         v = m ? f : shadow[s + 6'(i)];
         shadow[a] = v;
         exp_q.push_back('{a: a, d: v});
      end
   endtask

   task automatic mem_cmp(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (mem[i] !== shadow[i]) bad++;
      chk(name, 32'(bad), 0);
   endtask

   task automatic kick(input logic m,
                       input logic [5:0] s,
                       input logic [5:0] d,
                       input logic [6:0] l,
                       input logic [31:0] f);
      rd_cnt = 0;
      wr_cnt = 0;
      @(posedge clk);
      #1;
      Mode      = m;
      SrcAddr   = s;
      DstAddr   = d;
      Length    = l;
      FillValue = f;
      Start     = 1'b1;
      @(posedge clk);
      #1;
      Start     = 1'b0;
      SrcAddr   = ~s;
      DstAddr   = ~d;
      Length    = 7'd1;
      FillValue = ~f;
   endtask

   task automatic run(input vec_t v);
      int k;
      bit seen;
      plan(v.mode, v.src, v.dst, v.len, v.fill, 1000);
      kick(v.mode, v.src, v.dst, v.len, v.fill);
      k = 0;
      seen = 0;
      while (!seen && k < 200) begin
         @(negedge clk);
         k++;
         if (k == 1) chk("busy_c1", 32'(Busy), 1);
         if (v.restart && k == 2) begin
            Start  = 1'b1;
            Mode   = ~v.mode;
            Length = 7'd2;
         end
         if (v.restart && k == 3) Start = 1'b0;
         if (Done) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: k=%0d", k);
      end
      chk("done_lat", 32'(k), 32'(v.exp_cyc));
      chk("words_fin", 32'(WordsDone), 32'(v.exp_words));
      @(negedge clk);
      chk("busy_after", 32'(Busy), 0);
      chk("done_once", 32'(Done), 0);
      chk("aborted_no", 32'(Aborted), 0);
      chk("words_hold", 32'(WordsDone), 32'(v.exp_words));
      chk("wr_cnt", 32'(wr_cnt), 32'(v.exp_words));
      chk("rd_cnt", 32'(rd_cnt),
          v.mode ? 0 : 32'(v.exp_words));
      chk("sb_empty", 32'(exp_q.size()), 0);
      mem_cmp("mem_img");
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{0, 6'd2,  6'd10, 7'd4,  32'h0,         0, 9,  4};
      vecs[1] = '{1, 6'd0,  6'd60, 7'd6,  32'hDEADBEEF,  0, 7,  6};
      vecs[2] = '{0, 6'd7,  6'd20, 7'd0,  32'h0,         0, 1,  0};
      vecs[3] = '{0, 6'd20, 6'd22, 7'd5,  32'h0,         0, 11, 5};
      vecs[4] = '{0, 6'd62, 6'd30, 7'd3,  32'h0,         0, 7,  3};
      vecs[5] = '{1, 6'd0,  6'd0,  7'd10, 32'h1234_5678, 1, 11, 10};
      vecs[6] = '{1, 6'd0,  6'd5,  7'd70, 32'hCAFE_F00D,  0, 65, 64};

      for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
      rst_n     = 1'b0;
      mem_init  = 1'b1;
      Start     = 1'b0;
      Mode      = 1'b0;
      Abort     = 1'b0;
      SrcAddr   = '0;
      DstAddr   = '0;
      Length    = '0;
      FillValue = '0;
      repeat (2) @(posedge clk);
      #1;
      mem_init = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      chk("rst_busy",  32'(Busy), 0);
      chk("rst_done",  32'(Done), 0);
      chk("rst_abt",   32'(Aborted), 0);
      chk("rst_words", 32'(WordsDone), 0);
      chk("rst_rd",    32'(MemRead), 0);
      chk("rst_wr",    32'(MemWrite), 0);
      chk("rst_addr",  32'(Address), 0);
      chk("rst_wdata", WriteData, 0);

      for (int i = 0; i < 7; i++) run(vecs[i]);

      // Abort during the third write of an 8-word copy.
      plan(1'b0, 6'd0, 6'd40, 7'd8, 32'h0, 3);
      kick(1'b0, 6'd0, 6'd40, 7'd8, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      chk("abt_in_wr", 32'(MemWrite), 1);
      Abort = 1'b1;
      @(posedge clk);
      #1;
      Abort = 1'b0;
      @(negedge clk);
      chk("abt_pulse", 32'(Aborted), 1);
      chk("abt_done",  32'(Done), 0);
      chk("abt_busy",  32'(Busy), 0);
      chk("abt_words", 32'(WordsDone), 3);
      @(negedge clk);
      chk("abt_once",  32'(Aborted), 0);
      chk("abt_done2", 32'(Done), 0);
      chk("abt_wrcnt", 32'(wr_cnt), 3);
      chk("abt_rdcnt", 32'(rd_cnt), 3);
      chk("abt_sb",    32'(exp_q.size()), 0);
      mem_cmp("abt_mem");

      // Asynchronous reset while a write strobe is up.
      kick(1'b0, 6'd2, 6'd50, 7'd4, 32'h0);
      @(posedge clk);
      #2;
      chk("rst_mid_wr", 32'(MemWrite), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wr0",   32'(MemWrite), 0);
      chk("rst_mid_rd0",   32'(MemRead), 0);
      chk("rst_mid_busy0", 32'(Busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run('{0, 6'd2, 6'd50, 7'd1, 32'h0, 0, 3, 1});

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
